// File: rtl/network_sequencer.sv
// Control FSM that runs a chain of fully-connected layers one at a time per frame,
// handshaking layerValid/layerOutValid, pulsing capture enables and timing the frame.
module network_sequencer #(
  parameter int numLayers     = 3,
  parameter int timeoutCycles = 2048,
  parameter int countWidth    = 16,
  parameter int idxWidth      = (numLayers > 1) ? $clog2(numLayers) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frameStart,
  input  logic                  errClear,
  input  logic [numLayers-1:0]  layerOutValid,
  output logic [numLayers-1:0]  layerValid,
  output logic [numLayers-1:0]  captureEn,
  output logic [idxWidth-1:0]   activeLayer,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  error,
  output logic [countWidth-1:0] frameLatency
);

  localparam int waitWidth = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;

  localparam logic [waitWidth-1:0]  waitLast = waitWidth'(timeoutCycles - 1);
  localparam logic [idxWidth-1:0]   lastIdx  = idxWidth'(numLayers - 1);
  localparam logic [countWidth-1:0] latMax   = '1;
  localparam logic [numLayers-1:0]  oneHot   = numLayers'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [idxWidth-1:0]   idx_q, idx_d;
  logic [waitWidth-1:0]  wait_q, wait_d;
  logic [countWidth-1:0] lat_q, lat_d;
  logic [countWidth-1:0] frame_latency_q, frame_latency_d;
  logic [numLayers-1:0]  layer_valid_q, layer_valid_d;
  logic [numLayers-1:0]  capture_en_q, capture_en_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  error_q, error_d;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    wait_d          = wait_q;
    lat_d           = lat_q;
    frame_latency_d = frame_latency_q;

    // Frame latency saturates instead of wrapping on pathologically slow layers.
    if ((state_q inside {S_RUN, S_WAIT, S_CAPTURE, S_DONE}) && (lat_q != latMax)) begin
      lat_d = lat_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frameStart) begin
          idx_d   = '0;
          lat_d   = countWidth'(1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (layerOutValid[idx_q]) begin
          state_d = S_CAPTURE;
        end else if (wait_q == waitLast) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        wait_d = '0;
        if (idx_q == lastIdx) begin
          frame_latency_d = lat_q;
          state_d         = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (errClear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // NOTE: outputs are decoded from the next state so the registered copies line up with state_q.
    layer_valid_d = '0;
    capture_en_d  = '0;
    if (state_d == S_RUN || state_d == S_WAIT) begin
      layer_valid_d = oneHot << idx_d;
    end
    if (state_d == S_CAPTURE) begin
      capture_en_d = oneHot << idx_d;
    end
    busy_d       = !(state_d == S_IDLE || state_d == S_ERROR);
    frame_done_d = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      wait_q          <= '0;
      lat_q           <= '0;
      frame_latency_q <= '0;
      layer_valid_q   <= '0;
      capture_en_q    <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      wait_q          <= wait_d;
      lat_q           <= lat_d;
      frame_latency_q <= frame_latency_d;
      layer_valid_q   <= layer_valid_d;
      capture_en_q    <= capture_en_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      error_q         <= error_d;
    end
  end

  assign layerValid   = layer_valid_q;
  assign captureEn    = capture_en_q;
  assign activeLayer  = idx_q;
  assign busy         = busy_q;
  assign frameDone    = frame_done_q;
  assign error        = error_q;
  assign frameLatency = frame_latency_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Self-checking bench for network_sequencer: stub layers answer after a programmable
// number of WAIT cycles and a frame-level model predicts order, pulses and latency.
module tb_network_sequencer;

  localparam int NL = 3;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          frameStart;
  logic          errClear;
  logic [NL-1:0] layerOutValid;
  logic [NL-1:0] layerValid;
  logic [NL-1:0] captureEn;
  logic [1:0]    activeLayer;
  logic          busy;
  logic          frameDone;
  logic          error;
  logic [CW-1:0] frameLatency;

  int vectors     = 0;
  int miscompares = 0;

  int stub_n   [NL];
  int stub_cnt [NL];
  bit spurious2 = 1'b0;

  network_sequencer #(
    .numLayers    (NL),
    .timeoutCycles(TO),
    .countWidth   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frameStart   (frameStart),
    .errClear     (errClear),
    .layerOutValid(layerOutValid),
    .layerValid   (layerValid),
    .captureEn    (captureEn),
    .activeLayer  (activeLayer),
    .busy         (busy),
    .frameDone    (frameDone),
    .error        (error),
    .frameLatency (frameLatency)
  );

  always #5 clk = ~clk;

  // Advance one clock; stub layer i raises layerOutValid once n WAIT cycles have elapsed.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      if (layerValid[i]) stub_cnt[i]++;
      else stub_cnt[i] = 0;
      layerOutValid[i] = layerValid[i] && (stub_cnt[i] >= stub_n[i] + 2);
    end
    if (spurious2 && layerValid[0]) layerOutValid[NL-1] = 1'b1;
  endtask

  function automatic int idx_of(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Each layer costs RUN + CAPTURE + detection edge on top of its own compute time.
  function automatic int model_latency(input int n0, input int n1, input int n2);
    int sum;
    sum = (n0 + 3) + (n1 + 3) + (n2 + 3);
    if (sum > (1 << CW) - 1) sum = (1 << CW) - 1;
    return sum;
  endfunction

  task automatic do_frame(input string name, input int n0, input int n1, input int n2,
                          input bit poke);
    int seq_code, exp_code, done_cnt, viol, err_seen, tail, exp_lat;
    int cap_cnt [NL];
    logic [NL-1:0] prev_lv;
    bit finished;
    stub_n   = '{n0, n1, n2};
    exp_lat  = model_latency(n0, n1, n2);
    exp_code = 0;
    for (int i = 0; i < NL; i++) exp_code = exp_code * 4 + (i + 1);
    seq_code = 0; done_cnt = 0; viol = 0; err_seen = 0; tail = 0;
    finished = 1'b0; prev_lv = '0;
    for (int i = 0; i < NL; i++) cap_cnt[i] = 0;
    frameStart = 1'b1;
    for (int cyc = 0; cyc < 600 && tail < 6; cyc++) begin
      step();
      frameStart = 1'b0;
      if (!$onehot0(layerValid)) viol++;
      if (layerValid != '0 && prev_lv == '0) seq_code = seq_code * 4 + idx_of(layerValid) + 1;
      if (layerValid != '0 && int'(activeLayer) != idx_of(layerValid)) viol++;
      if (captureEn != '0 && captureEn !== prev_lv) viol++;
      for (int i = 0; i < NL; i++) cap_cnt[i] += int'(captureEn[i]);
      if (finished && !frameDone && busy) viol++;
      if (frameDone) begin done_cnt++; finished = 1'b1; end
      if (error) err_seen++;
      if (finished) tail++;
      if (poke && ((layerValid[0] && stub_cnt[0] == 3) || frameDone)) frameStart = 1'b1;
      prev_lv = layerValid;
    end
    frameStart = 1'b0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL %s frame_timeout: frameDone not seen within cycle budget", name);
    end
    vectors++;
    if (seq_code !== exp_code) begin
      miscompares++;
      $display("FAIL %s layer_order: got code %0d expected %0d", name, seq_code, exp_code);
    end
    for (int i = 0; i < NL; i++) begin
      vectors++;
      if (cap_cnt[i] !== 1) begin
        miscompares++;
        $display("FAIL %s capture_count[%0d]: got %0d expected 1", name, i, cap_cnt[i]);
      end
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s frame_done_count: got %0d expected 1", name, done_cnt);
    end
    vectors++;
    if (frameLatency !== exp_lat[CW-1:0]) begin
      miscompares++;
      $display("FAIL %s frame_latency: got %0d expected %0d", name, frameLatency, exp_lat);
    end
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL %s protocol: got %0d violations expected 0", name, viol);
    end
    vectors++;
    if (err_seen !== 0) begin
      miscompares++;
      $display("FAIL %s error_flag: got %0d error cycles expected 0", name, err_seen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frameStart = 1'b0; errClear = 1'b0; layerOutValid = '0;
    for (int i = 0; i < NL; i++) begin stub_n[i] = 0; stub_cnt[i] = 0; end
    step();
    step();
    vectors++;
    if ({layerValid, captureEn, activeLayer, busy, frameDone, error} !== '0 || frameLatency !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got lv=%b cap=%b act=%0d busy=%b done=%b err=%b lat=%0d expected all 0",
               layerValid, captureEn, activeLayer, busy, frameDone, error, frameLatency);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int lv1, done_cnt;
    bit got;
    stub_n = '{3, 1000, 3};
    lv1 = 0; done_cnt = 0; got = 1'b0;
    frameStart = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      frameStart = 1'b0;
      if (layerValid[1]) lv1++;
      if (frameDone) done_cnt++;
      if (error) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL timeout_error: error not raised within cycle budget");
    end
    vectors++;
    if (lv1 !== 1 + TO) begin
      miscompares++;
      $display("FAIL timeout_wait_cycles: got %0d layer1 valid cycles expected %0d", lv1, 1 + TO);
    end
    vectors++;
    if (activeLayer !== 2'd1 || layerValid !== '0 || busy !== 1'b0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL timeout_outputs: got act=%0d lv=%b busy=%b done=%0d expected 1 000 0 0",
               activeLayer, layerValid, busy, done_cnt);
    end
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    step();
    vectors++;
    if (error !== 1'b1 || layerValid !== '0) begin
      miscompares++;
      $display("FAIL error_ignores_start: got err=%b lv=%b expected 1 000", error, layerValid);
    end
    errClear = 1'b1;
    step();
    errClear = 1'b0;
    step();
    vectors++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b busy=%b expected 0 0", error, busy);
    end
    do_frame("after_clear", 4, 2, 6, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int cap_cnt, done_cnt, busy_cnt;
    bit reached;
    stub_n = '{2, 50, 2};
    reached = 1'b0;
    frameStart = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      frameStart = 1'b0;
      if (layerValid[1] && stub_cnt[1] == 4) begin reached = 1'b1; break; end
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL midframe_reach: layer 1 WAIT not reached within cycle budget");
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({layerValid, captureEn, activeLayer, busy, frameDone, error} !== '0 || frameLatency !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset_state: got lv=%b cap=%b act=%0d busy=%b done=%b err=%b lat=%0d expected all 0",
               layerValid, captureEn, activeLayer, busy, frameDone, error, frameLatency);
    end
    reset = 1'b0;
    cap_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (captureEn != '0) cap_cnt++;
      if (frameDone) done_cnt++;
      if (busy) busy_cnt++;
    end
    vectors++;
    if (cap_cnt !== 0 || done_cnt !== 0 || busy_cnt !== 0) begin
      miscompares++;
      $display("FAIL midframe_abort: got cap=%0d done=%0d busy=%0d expected 0 0 0",
               cap_cnt, done_cnt, busy_cnt);
    end
  endtask

  task automatic test_basic();
    do_frame("basic", 5, 7, 4, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_frame("ignore_start", 4, 3, 1, 1'b1);
    do_frame("next_accepted", 1, 2, 3, 1'b0);
  endtask

  task automatic test_spurious_valid();
    spurious2 = 1'b1;
    do_frame("spurious_valid", 6, 2, 3, 1'b0);
    spurious2 = 1'b0;
  endtask

  task automatic test_terminal_race();
    do_frame("terminal_race", TO - 1, 0, TO - 1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_frame("random", int'($urandom_range(TO - 1, 0)), int'($urandom_range(TO - 1, 0)),
               int'($urandom_range(TO - 1, 0)), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_ignore_start();
    test_spurious_valid();
    test_terminal_race();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
